flow_rr_scheduler: RTL and testbench

//  Controller in front of the per-flow rank store: admits enqueues into a per-flow FIFO, tracks occupancy,
//  and serves dequeues by picking a non-empty flow round-robin and sequencing the store's 1-cycle pop.

---
 rtl/flow_rr_scheduler_pkg.sv | 13 +
 rtl/flow_rr_scheduler_if.sv | 49 ++++
 rtl/flow_rr_scheduler_rr_arbiter.sv | 24 ++
 rtl/flow_rr_scheduler.sv | 143 ++++++++++++++
 tb/tb_flow_rr_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flow_rr_scheduler_pkg.sv
// Shared types and widths for the per-flow round-robin scheduler.
package flow_rr_scheduler_pkg;

    localparam int DATA_W = 32;
    localparam int RANK_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

endpackage

// File: rtl/flow_rr_scheduler_if.sv
// Ingress, egress and rank-store signals of the scheduler grouped in one bundle.
interface flow_rr_scheduler_if #(
    parameter int FLOWS = 10
);
    import flow_rr_scheduler_pkg::*;

    logic                enq_valid;
    logic                enq_ready;
    logic [FLOWS-1:0]    enq_flow;
    logic [RANK_W-1:0]   enq_rank;
    logic [DATA_W-1:0]   enq_value;

    logic                deq_valid;
    logic                deq_ready;
    logic [DATA_W-1:0]   deq_value;
    logic [RANK_W-1:0]   deq_rank;
    logic [FLOWS-1:0]    deq_flow;

    logic                st_push;
    logic [FLOWS-1:0]    st_push_flow;
    logic [RANK_W-1:0]   st_push_rank;
    logic [DATA_W-1:0]   st_push_value;
    logic                st_pop;
    logic [FLOWS-1:0]    st_pop_flow;
    logic [DATA_W-1:0]   st_pop_value;
    logic [RANK_W-1:0]   st_pop_rank;
    logic                st_pop_valid;

    logic                err;

    // Scheduler side
    modport slave (
        input  enq_valid, enq_flow, enq_rank, enq_value, deq_ready,
               st_pop_value, st_pop_rank, st_pop_valid,
        output enq_ready, deq_valid, deq_value, deq_rank, deq_flow,
               st_push, st_push_flow, st_push_rank, st_push_value,
               st_pop, st_pop_flow, err
    );

    // Environment side: producer, consumer and rank store
    modport master (
        output enq_valid, enq_flow, enq_rank, enq_value, deq_ready,
               st_pop_value, st_pop_rank, st_pop_valid,
        input  enq_ready, deq_valid, deq_value, deq_rank, deq_flow,
               st_push, st_push_flow, st_push_rank, st_push_value,
               st_pop, st_pop_flow, err
    );

endinterface

// File: rtl/flow_rr_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above the one-hot pointer, wrapping.
module rr_arbiter #(
    parameter int N = 10
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] grant,
    output logic         any
);

    logic [N-1:0] upper;

    // Requests at or above ptr win; isolate lowest set bit with x & -x
    always_comb begin
        upper = req & ~(ptr - N'(1));
        if (upper != '0) begin
            grant = upper & (~upper + N'(1));
        end else begin
            grant = req & (~req + N'(1));
        end
        any = |req;
    end

endmodule

// File: rtl/flow_rr_scheduler.sv
// Per-flow admission, occupancy tracking and round-robin pop sequencing in front of the rank store.
module flow_rr_scheduler
    import flow_rr_scheduler_pkg::*;
#(
    parameter int SIZE  = 50,
    parameter int FLOWS = 10
) (
    input logic                clk,
    input logic                rst,
    flow_rr_scheduler_if.slave bus
);

    localparam int CNT_W = $clog2(SIZE + 1);

    logic [CNT_W-1:0] count [FLOWS];
    logic [FLOWS-1:0] eligible;
    logic [FLOWS-1:0] not_full;
    logic [FLOWS-1:0] rr_ptr;
    logic [FLOWS-1:0] grant;
    logic [FLOWS-1:0] pend_flow;
    logic [FLOWS-1:0] pop_flow;
    logic             any_eligible;
    logic             flow_onehot;
    logic             enq_ready;
    logic             push;
    logic             pop;
    sched_state_t     state;
    sched_state_t     state_next;

    // Admission only looks at start-of-cycle counts, so a same-cycle pop never frees room
    always_comb begin
        for (int f = 0; f < FLOWS; f++) begin
            eligible[f] = (count[f] != '0);
            not_full[f] = (count[f] < CNT_W'(SIZE));
        end
        flow_onehot = (bus.enq_flow != '0) &&
                      ((bus.enq_flow & (bus.enq_flow - FLOWS'(1))) == '0);
        enq_ready   = flow_onehot && ((bus.enq_flow & not_full) != '0);
        push        = bus.enq_valid && enq_ready;
    end

    assign bus.enq_ready     = enq_ready;
    assign bus.st_push       = push;
    assign bus.st_push_flow  = bus.enq_flow;
    assign bus.st_push_rank  = bus.enq_rank;
    assign bus.st_push_value = bus.enq_value;
    assign bus.st_pop        = pop;
    assign bus.st_pop_flow   = pop_flow;

    rr_arbiter #(.N(FLOWS)) u_arbiter (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any_eligible)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pop engine: WAIT always separates two pops, capping throughput at one entry per two cycles
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        pop_flow   = '0;
        case (state)
            IDLE: begin
                if (any_eligible) begin
                    pop        = 1'b1;
                    pop_flow   = grant;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (bus.deq_ready) begin
                    if (any_eligible) begin
                        pop        = 1'b1;
                        pop_flow   = grant;
                        state_next = WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLOWS; f++) begin
                count[f] <= '0;
            end
        end else begin
            for (int f = 0; f < FLOWS; f++) begin
                case ({push && bus.enq_flow[f], pop && pop_flow[f]})
                    2'b10:   count[f] <= count[f] + CNT_W'(1);
                    2'b01:   count[f] <= count[f] - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Output register is loaded from the store read data in WAIT and held through HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= FLOWS'(1);
            pend_flow     <= '0;
            bus.deq_valid <= 1'b0;
            bus.deq_value <= '0;
            bus.deq_rank  <= '0;
            bus.deq_flow  <= '0;
            bus.err       <= 1'b0;
        end else begin
            if (pop) begin
                rr_ptr    <= {grant[FLOWS-2:0], grant[FLOWS-1]};
                pend_flow <= grant;
            end
            if (state == WAIT) begin
                bus.deq_value <= bus.st_pop_value;
                bus.deq_rank  <= bus.st_pop_rank;
                bus.deq_flow  <= pend_flow;
                bus.deq_valid <= 1'b1;
                if (!bus.st_pop_valid) begin
                    bus.err <= 1'b1;
                end
            end else if (state == HOLD && bus.deq_ready) begin
                bus.deq_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flow_rr_scheduler.sv
// Randomized scoreboard bench for flow_rr_scheduler with a behavioural rank store.
module tb_flow_rr_scheduler;
    import flow_rr_scheduler_pkg::*;

    localparam int FLOWS = 4;
    localparam int SIZE  = 4;

    typedef struct packed {
        logic [RANK_W-1:0] rank;
        logic [DATA_W-1:0] value;
    } entry_t;

    typedef struct packed {
        logic [FLOWS-1:0] flow;
        entry_t           e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    bit   drop_mode;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    flow_rr_scheduler_if #(.FLOWS(FLOWS)) bus ();

    flow_rr_scheduler #(.SIZE(SIZE), .FLOWS(FLOWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int flow_idx(input logic [FLOWS-1:0] v);
        for (int i = 0; i < FLOWS; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [FLOWS-1:0] fl,
                                 input logic [31:0] rk, input logic [31:0] vl, input logic rdy);
        bus.enq_valid = v;
        bus.enq_flow  = fl;
        bus.enq_rank  = rk;
        bus.enq_value = vl;
        bus.deq_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Rank store: per-flow FIFOs, read data registered one cycle after st_pop
    entry_t store_q [FLOWS][$];

    always @(posedge clk) begin
        entry_t e;
        if (rst) begin
            for (int f = 0; f < FLOWS; f++) store_q[f].delete();
            bus.st_pop_valid <= 1'b0;
            bus.st_pop_value <= '0;
            bus.st_pop_rank  <= '0;
        end else begin
            if (bus.st_pop) begin
                e = '0;
                if (store_q[flow_idx(bus.st_pop_flow)].size() > 0)
                    e = store_q[flow_idx(bus.st_pop_flow)].pop_front();
                bus.st_pop_value <= e.value;
                bus.st_pop_rank  <= e.rank;
                bus.st_pop_valid <= !drop_mode;
            end else begin
                bus.st_pop_valid <= 1'b0;
            end
            if (bus.st_push) begin
                e.rank  = bus.st_push_rank;
                e.value = bus.st_push_value;
                store_q[flow_idx(bus.st_push_flow)].push_back(e);
            end
        end
    end

    // Reference model: per-flow queues, integer rr pointer, phase 0=idle 1=fetching 2=presenting
    entry_t mq [FLOWS][$];
    exp_t   exp_q [$];
    int     m_ptr;
    int     m_phase;
    bit     m_err;
    bit     m_drop;

    always @(negedge clk) begin
        int               f;
        int               sel;
        int               k;
        bit               exp_ready;
        bit               pop_now;
        logic [FLOWS-1:0] exp_pop_flow;
        exp_t             x;
        if (rst) begin
            for (int i = 0; i < FLOWS; i++) mq[i].delete();
            exp_q.delete();
            m_ptr   = 0;
            m_phase = 0;
            m_err   = 1'b0;
            m_drop  = 1'b0;
        end else begin
            f         = flow_idx(bus.enq_flow);
            exp_ready = ($countones(bus.enq_flow) == 1) && (mq[f].size() < SIZE);
            checkOutput("enq_ready", 64'(bus.enq_ready), 64'(exp_ready));
            checkOutput("st_push", 64'(bus.st_push), 64'(bus.enq_valid && exp_ready));
            checkOutput("deq_valid", 64'(bus.deq_valid), 64'(m_phase == 2));
            checkOutput("err", 64'(bus.err), 64'(m_err));

            sel = -1;
            for (int i = 0; i < FLOWS; i++) begin
                k = (m_ptr + i) % FLOWS;
                if (sel < 0 && mq[k].size() > 0) sel = k;
            end
            pop_now      = (sel >= 0) && (m_phase == 0 || (m_phase == 2 && bus.deq_ready));
            exp_pop_flow = pop_now ? FLOWS'(1 << sel) : '0;
            checkOutput("st_pop", 64'(bus.st_pop), 64'(pop_now));
            checkOutput("st_pop_flow", 64'(bus.st_pop_flow), 64'(exp_pop_flow));

            if (m_phase == 1) begin
                if (m_drop) m_err = 1'b1;
                m_phase = 2;
            end else if (m_phase == 2 && bus.deq_ready && !pop_now) begin
                m_phase = 0;
            end
            if (pop_now) begin
                x.flow = exp_pop_flow;
                x.e    = mq[sel].pop_front();
                exp_q.push_back(x);
                m_ptr   = (sel + 1) % FLOWS;
                m_phase = 1;
                m_drop  = drop_mode;
            end
            if (bus.enq_valid && exp_ready) begin
                x.e.rank  = bus.enq_rank;
                x.e.value = bus.enq_value;
                mq[f].push_back(x.e);
            end
        end
    end

    // Monitor: presented entry must match the oldest expected one and stay stable until taken
    always @(negedge clk) begin
        if (!rst && bus.deq_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL deq_unexpected actual=%0h expected=none at %0t", bus.deq_value, $time);
            end else begin
                checkOutput("deq_value", 64'(bus.deq_value), 64'(exp_q[0].e.value));
                checkOutput("deq_rank", 64'(bus.deq_rank), 64'(exp_q[0].e.rank));
                checkOutput("deq_flow", 64'(bus.deq_flow), 64'(exp_q[0].flow));
                if (bus.deq_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic doReset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 4'b0001, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic idle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 4'b0001, 32'd0, 32'd0, rdy);
    endtask

    initial begin
        logic [FLOWS-1:0] fl;
        int               r;
        bit               reached;
        rst       = 1'b1;
        drop_mode = 1'b0;
        doReset(2);

        $display("[TB] reset state and single entry");
        idle(1, 1'b0);
        applyStimulus(1'b1, 4'b0001, 32'd5, 32'hA, 1'b1);
        idle(5, 1'b1);

        $display("[TB] fill flow2 past capacity then drain");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'b0100, 32'(100 + i), 32'(32'hB0 + i), 1'b0);
        idle(14, 1'b1);

        $display("[TB] round robin across flows 0,1,3");
        doReset(1);
        applyStimulus(1'b1, 4'b0001, 32'd1, 32'hC0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 32'd2, 32'hC1, 1'b0);
        applyStimulus(1'b1, 4'b1000, 32'd3, 32'hC3, 1'b0);
        applyStimulus(1'b1, 4'b0001, 32'd4, 32'hC4, 1'b1);
        idle(10, 1'b1);

        $display("[TB] consumer stall in HOLD");
        applyStimulus(1'b1, 4'b0010, 32'd7, 32'hD1, 1'b0);
        applyStimulus(1'b1, 4'b0100, 32'd8, 32'hD2, 1'b0);
        idle(5, 1'b0);
        idle(6, 1'b1);

        $display("[TB] missing store read-valid sets sticky err");
        drop_mode = 1'b1;
        applyStimulus(1'b1, 4'b1000, 32'd9, 32'hE1, 1'b0);
        idle(3, 1'b0);
        drop_mode = 1'b0;
        idle(6, 1'b1);

        $display("[TB] multi-hot select and reset during fetch");
        applyStimulus(1'b1, 4'b0011, 32'd1, 32'hF0, 1'b1);
        applyStimulus(1'b1, 4'b0000, 32'd1, 32'hF1, 1'b1);
        applyStimulus(1'b1, 4'b0001, 32'd2, 32'hF2, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            if (m_phase == 1) reached = 1'b1;
            else idle(1, 1'b1);
        end
        if (!reached) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_fetch actual=timeout expected=fetch_phase");
        end
        doReset(1);
        idle(4, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      fl = '0;
            else if (r == 1) fl = FLOWS'($urandom_range(0, 15));
            else             fl = FLOWS'(1 << $urandom_range(0, FLOWS - 1));
            applyStimulus(1'($urandom_range(0, 2) != 0), fl, $urandom, $urandom,
                          (i % 100) < 60 ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 5) == 0));
        end
        idle(60, 1'b1);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
